// File: rtl/priority_encoder_q_if.sv
// Request/grant bundle between event sources, the priority encoder and its consumer.
// Signals only; no timing of its own.
// The consumer side (master) drives out_ready; the encoder side (slave) drives out_valid.
interface priority_encoder_q_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic [N-1:0] req_in;
    logic         clr_all;
    logic [W-1:0] out_idx;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] pending;
    logic         coalesce;

    // Source/consumer side: raises requests and flushes, accepts indices.
    modport master (
        output req_in, clr_all, out_ready,
        input  out_idx, out_valid, pending, coalesce
    );

    // Encoder side.
    modport slave (
        input  req_in, clr_all, out_ready,
        output out_idx, out_valid, pending, coalesce
    );
endinterface

// File: rtl/priority_encoder_q.sv
// Queued N-to-log2(N) priority encoder: latches request pulses, presents the top pending index.
// Latency: request at edge t is presented at t+1 when idle; one index per cycle back-to-back.
// Backpressure: while out_ready is low the presented index is frozen; new requests queue in pending.
// Optional: define ROUND_ROBIN_EN for rotating priority (pointer search); default is fixed, highest index wins.
module priority_encoder_q #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    priority_encoder_q_if.slave  bus
);
    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [W-1:0] idx_next;
    logic         accept;
    logic [N-1:0] served;
    logic [N-1:0] next_pending;
    logic         coalesce_next;
    logic [W-1:0] sel_idx;

    assign accept       = bus.out_valid & bus.out_ready;
    assign served       = accept ? (N'(1) << bus.out_idx) : '0;
    // A line re-requested while being served keeps its bit: the new event wins.
    assign next_pending = bus.clr_all ? '0 : ((bus.pending & ~served) | bus.req_in);
    assign coalesce_next = ~bus.clr_all & (|(bus.req_in & bus.pending & ~served));
    assign bus.out_valid = (state == HOLD);

`ifdef ROUND_ROBIN_EN
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_next;

    // Search downward from p (inclusive), wrapping N-1..0; the nearest hit below p wins.
    function automatic logic [W-1:0] sel_rr(input logic [N-1:0] v, input logic [W-1:0] p);
        logic [W-1:0] r;
        int j;
        r = '0;
        for (int off = N - 1; off >= 0; off--) begin
            j = int'(p) - off;
            if (j < 0) j = j + N;
            if (v[j]) r = W'(j);
        end
        return r;
    endfunction

    // The selection made on an accept must already see the advanced pointer.
    assign ptr_next = (accept && !bus.clr_all) ?
                      ((bus.out_idx == '0) ? W'(N - 1) : bus.out_idx - W'(1)) : ptr;
    assign sel_idx  = sel_rr(next_pending, ptr_next);

    // Rotation pointer; starts at N-1 so the first pick matches fixed priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= W'(N - 1);
        else     ptr <= ptr_next;
    end
`else
    // Fixed priority: highest set index wins; indices >= N never appear.
    function automatic logic [W-1:0] sel_fixed(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = W'(i);
        end
        return r;
    endfunction

    assign sel_idx = sel_fixed(next_pending);
`endif

    // Output FSM next state: load a new index from idle or right after an accept.
    always_comb begin
        state_next = state;
        idx_next   = bus.out_idx;
        case (state)
            IDLE: begin
                if (|next_pending) begin
                    idx_next   = sel_idx;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (|next_pending) begin
                        idx_next   = sel_idx;
                        state_next = HOLD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // A flush drops the presented index along with everything queued.
        if (bus.clr_all) state_next = IDLE;
    end

    // State, presented index, pending vector and coalesce pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bus.out_idx  <= '0;
            bus.pending  <= '0;
            bus.coalesce <= 1'b0;
        end else begin
            state        <= state_next;
            bus.out_idx  <= idx_next;
            bus.pending  <= next_pending;
            bus.coalesce <= coalesce_next;
        end
    end
endmodule

// File: tb/tb_priority_encoder_q.sv
// Directed bench for priority_encoder_q (N=8) with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled at that point too.
// Covers reset, queue drain order, backpressure freeze, coalesce, re-request, flush, async reset.
`timescale 1ns/1ps
module tb_priority_encoder_q;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    priority_encoder_q_if #(.N(8)) bus ();

    priority_encoder_q #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] rr_exp [4];
    int         drain;

    initial begin
        checks   = 0;
        failures = 0;
        rst           = 1'b1;
        bus.req_in    = '0;
        bus.clr_all   = 1'b0;
        bus.out_ready = 1'b0;
`ifdef ROUND_ROBIN_EN
        rr_exp = '{3'd7, 3'd0, 3'd7, 3'd0};
`else
        rr_exp = '{3'd7, 3'd7, 3'd7, 3'd7};
`endif
        tick();
        tick();
        chk("rst_pending", 32'(bus.pending), 32'h0);
        chk("rst_valid",   32'(bus.out_valid), 32'h0);
        chk("rst_idx",     32'(bus.out_idx), 32'h0);
        chk("rst_coal",    32'(bus.coalesce), 32'h0);
        rst = 1'b0;
        tick();

        // 1: two queued requests drain highest first.
        bus.out_ready = 1'b1;
        bus.req_in = 8'hA0;
        tick();
        bus.req_in = 8'h00;
        chk("t1_valid_a", 32'(bus.out_valid), 32'h1);
        chk("t1_idx_a",   32'(bus.out_idx), 32'd7);
        chk("t1_pend_a",  32'(bus.pending), 32'hA0);
        tick();
        chk("t1_valid_b", 32'(bus.out_valid), 32'h1);
        chk("t1_idx_b",   32'(bus.out_idx), 32'd5);
        chk("t1_pend_b",  32'(bus.pending), 32'h20);
        tick();
        chk("t1_valid_c", 32'(bus.out_valid), 32'h0);
        chk("t1_pend_c",  32'(bus.pending), 32'h0);

        // 2: presented index frozen under backpressure despite higher request.
        bus.out_ready = 1'b0;
        bus.req_in = 8'h08;
        tick();
        bus.req_in = 8'h00;
        chk("t2_idx_a", 32'(bus.out_idx), 32'd3);
        bus.req_in = 8'h40;
        tick();
        bus.req_in = 8'h00;
        chk("t2_idx_b",  32'(bus.out_idx), 32'd3);
        chk("t2_pend_b", 32'(bus.pending), 32'h48);
        tick();
        tick();
        chk("t2_idx_c",   32'(bus.out_idx), 32'd3);
        chk("t2_valid_c", 32'(bus.out_valid), 32'h1);
        bus.out_ready = 1'b1;
        tick();
        chk("t2_idx_d",   32'(bus.out_idx), 32'd6);
        chk("t2_valid_d", 32'(bus.out_valid), 32'h1);
        tick();
        chk("t2_valid_e", 32'(bus.out_valid), 32'h0);

        // 3: repeat request on an unserved line coalesces.
        bus.out_ready = 1'b0;
        bus.req_in = 8'h04;
        tick();
        bus.req_in = 8'h00;
        chk("t3_idx_a",  32'(bus.out_idx), 32'd2);
        chk("t3_coal_a", 32'(bus.coalesce), 32'h0);
        tick();
        bus.req_in = 8'h04;
        tick();
        bus.req_in = 8'h00;
        chk("t3_coal_b", 32'(bus.coalesce), 32'h1);
        chk("t3_pend_b", 32'(bus.pending), 32'h04);
        tick();
        chk("t3_coal_c", 32'(bus.coalesce), 32'h0);
        bus.out_ready = 1'b1;
        tick();
        chk("t3_valid_d", 32'(bus.out_valid), 32'h0);
        chk("t3_pend_d",  32'(bus.pending), 32'h0);

        // 4: re-request of the line being accepted keeps it pending.
        bus.out_ready = 1'b0;
        bus.req_in = 8'h10;
        tick();
        bus.req_in = 8'h00;
        chk("t4_idx_a", 32'(bus.out_idx), 32'd4);
        bus.out_ready = 1'b1;
        bus.req_in = 8'h10;
        tick();
        bus.req_in = 8'h00;
        chk("t4_valid_b", 32'(bus.out_valid), 32'h1);
        chk("t4_idx_b",   32'(bus.out_idx), 32'd4);
        chk("t4_pend_b",  32'(bus.pending), 32'h10);
        chk("t4_coal_b",  32'(bus.coalesce), 32'h0);
        tick();
        chk("t4_valid_c", 32'(bus.out_valid), 32'h0);

        // 5: flush wins over a simultaneous request.
        bus.out_ready = 1'b0;
        bus.req_in = 8'hFF;
        tick();
        bus.req_in = 8'h00;
        chk("t5_pend_a", 32'(bus.pending), 32'hFF);
        chk("t5_idx_a",  32'(bus.out_idx), 32'd7);
        bus.clr_all = 1'b1;
        bus.req_in  = 8'h01;
        tick();
        bus.clr_all = 1'b0;
        bus.req_in  = 8'h00;
        chk("t5_pend_b",  32'(bus.pending), 32'h0);
        chk("t5_valid_b", 32'(bus.out_valid), 32'h0);
        chk("t5_coal_b",  32'(bus.coalesce), 32'h0);

        // 5b: asynchronous reset in the middle of HOLD.
        bus.req_in = 8'h20;
        tick();
        bus.req_in = 8'h00;
        chk("t5_valid_c", 32'(bus.out_valid), 32'h1);
        chk("t5_idx_c",   32'(bus.out_idx), 32'd5);
        rst = 1'b1;
        #1;
        chk("t5_arst_valid", 32'(bus.out_valid), 32'h0);
        chk("t5_arst_idx",   32'(bus.out_idx), 32'h0);
        chk("t5_arst_pend",  32'(bus.pending), 32'h0);
        #1;
        rst = 1'b0;
        tick();
        chk("t5_post_valid", 32'(bus.out_valid), 32'h0);
        chk("t5_post_pend",  32'(bus.pending), 32'h0);

        // 6: continuous requests on lines 7 and 0.
        bus.out_ready = 1'b1;
        bus.req_in = 8'h81;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t6_idx_%0d", k), 32'(bus.out_idx), 32'(rr_exp[k]));
        end
        bus.req_in = 8'h00;
        drain = 0;
        while (bus.out_valid && drain < 4) begin
            tick();
            drain++;
        end
        chk("t6_drained", 32'(bus.out_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
